// File: rtl/pc_watch_monitor.sv
// Program-counter watchdog: counts RUN cycles and halts on a final address,
// a breakpoint hit, a stuck PC or a cycle timeout, latching the cause.
module pc_watch_monitor #(
    parameter int ADDR_SIZE   = 32,
    parameter int NUM_BP      = 4,
    parameter int CNT_W       = 32,
    parameter int STALL_LIMIT = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        en,
    input  logic                        clr,
    input  logic [ADDR_SIZE-1:0]        pc,
    input  logic [ADDR_SIZE-1:0]        halt_addr,
    input  logic [NUM_BP*ADDR_SIZE-1:0] bp_addr,
    input  logic [NUM_BP-1:0]           bp_en,
    input  logic [CNT_W-1:0]            max_cycles,
    output logic [CNT_W-1:0]            cycle_cnt,
    output logic                        halted,
    output logic                        halt_evt,
    output logic [2:0]                  halt_cause,
    output logic [ADDR_SIZE-1:0]        halt_pc,
    output logic [NUM_BP-1:0]           bp_hit,
    output logic [1:0]                  dbg_state
);

    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   evt_q, evt_d;
    logic [2:0]             cause_q, cause_d;
    logic [ADDR_SIZE-1:0]   hpc_q, hpc_d;
    logic [NUM_BP-1:0]      hit_q, hit_d;
    logic [STALL_W-1:0]     stall_q, stall_d;
    logic [ADDR_SIZE-1:0]   prev_q, prev_d;
    logic                   prev_vld_q, prev_vld_d;

    logic [CNT_W-1:0]       cnt_inc;
    logic                   bp_any;
    logic [NUM_BP-1:0]      bp_onehot;
    logic                   same_pc;
    logic                   stuck;
    logic                   timeout;

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign same_pc = prev_vld_q && (pc == prev_q);
    // stall_q counts repeats before this edge, so this edge makes STALL_LIMIT
    assign stuck   = same_pc && (stall_q == STALL_W'(STALL_LIMIT - 1));
    assign timeout = (max_cycles != '0) && (cnt_inc == max_cycles);

    // Scanning downward leaves the lowest matching channel as the winner
    always_comb begin
        bp_any    = 1'b0;
        bp_onehot = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_en[i] && (pc == bp_addr[i*ADDR_SIZE +: ADDR_SIZE])) begin
                bp_any       = 1'b1;
                bp_onehot    = '0;
                bp_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        evt_d      = 1'b0;
        cause_d    = cause_q;
        hpc_d      = hpc_q;
        hit_d      = hit_q;
        stall_d    = stall_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        if (clr) begin
            state_d    = IDLE;
            cnt_d      = '0;
            cause_d    = 3'd0;
            hpc_d      = '0;
            hit_d      = '0;
            stall_d    = '0;
            prev_d     = '0;
            prev_vld_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_d    = RUN;
                        stall_d    = '0;
                        prev_vld_d = 1'b0;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state_d    = IDLE;
                        stall_d    = '0;
                        prev_vld_d = 1'b0;
                    end else begin
                        cnt_d      = cnt_inc;
                        prev_d     = pc;
                        prev_vld_d = 1'b1;
                        stall_d    = same_pc ? stall_q + STALL_W'(1) : '0;
                        if (pc == halt_addr) begin
                            cause_d = 3'd1;
                        end else if (bp_any) begin
                            cause_d = 3'd2;
                            hit_d   = bp_onehot;
                        end else if (stuck) begin
                            cause_d = 3'd3;
                        end else if (timeout) begin
                            cause_d = 3'd4;
                        end
                        if ((pc == halt_addr) || bp_any || stuck || timeout) begin
                            state_d = HALTED;
                            evt_d   = 1'b1;
                            hpc_d   = pc;
                        end
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            evt_q      <= 1'b0;
            cause_q    <= 3'd0;
            hpc_q      <= '0;
            hit_q      <= '0;
            stall_q    <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            evt_q      <= evt_d;
            cause_q    <= cause_d;
            hpc_q      <= hpc_d;
            hit_q      <= hit_d;
            stall_q    <= stall_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
        end
    end

    assign cycle_cnt  = cnt_q;
    assign halted     = (state_q == HALTED);
    assign halt_evt   = evt_q;
    assign halt_cause = cause_q;
    assign halt_pc    = hpc_q;
    assign bp_hit     = hit_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_pc_watch_monitor.sv
// Scoreboard bench for pc_watch_monitor: a behavioural model predicts the
// outputs after every clock edge and a monitor compares them at the falling edge.
module tb_pc_watch_monitor;

    localparam int AW = 32;
    localparam int NB = 4;
    localparam int CW = 32;
    localparam int SL = 16;
    localparam int SW = CW + 1 + 1 + 3 + AW + NB;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             en = 1'b0;
    logic             clr = 1'b0;
    logic [AW-1:0]    pc = '0;
    logic [AW-1:0]    halt_addr = '0;
    logic [NB*AW-1:0] bp_addr = '0;
    logic [NB-1:0]    bp_en = '0;
    logic [CW-1:0]    max_cycles = '0;
    logic [CW-1:0]    cycle_cnt;
    logic             halted;
    logic             halt_evt;
    logic [2:0]       halt_cause;
    logic [AW-1:0]    halt_pc;
    logic [NB-1:0]    bp_hit;
    logic [1:0]       dbg_state;

    logic [AW-1:0]    bp_tab[NB];

    int n_checks = 0;
    int n_pass   = 0;

    logic [SW-1:0] exp_q[$];

    // model state: mode 0 idle, 1 run, 2 halted
    int            m_mode = 0;
    logic [CW-1:0] m_cnt = '0;
    logic          m_evt = 1'b0;
    logic [2:0]    m_cause = '0;
    logic [AW-1:0] m_hpc = '0;
    logic [NB-1:0] m_hit = '0;
    logic [AW-1:0] m_hist[$];

    always #5 clk = ~clk;

    pc_watch_monitor #(
        .ADDR_SIZE(AW), .NUM_BP(NB), .CNT_W(CW), .STALL_LIMIT(SL)
    ) dut (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .pc(pc),
        .halt_addr(halt_addr), .bp_addr(bp_addr), .bp_en(bp_en),
        .max_cycles(max_cycles), .cycle_cnt(cycle_cnt), .halted(halted),
        .halt_evt(halt_evt), .halt_cause(halt_cause), .halt_pc(halt_pc),
        .bp_hit(bp_hit), .dbg_state(dbg_state)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [SW-1:0] pack_exp();
        return {m_cnt, (m_mode == 2), m_evt, m_cause, m_hpc, m_hit};
    endfunction

    function automatic void m_reset();
        m_mode = 0; m_cnt = '0; m_evt = 1'b0; m_cause = '0; m_hpc = '0; m_hit = '0;
        m_hist.delete();
    endfunction

    // Stuck: the last SL+1 PCs of the current run segment are all equal
    function automatic bit m_stuck();
        if (m_hist.size() < SL + 1) return 1'b0;
        foreach (m_hist[i]) if (m_hist[i] !== m_hist[0]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_edge();
        logic [2:0]    cause;
        logic [NB-1:0] hit;
        m_evt = 1'b0;
        if (!rstn || clr) begin
            m_reset();
            return;
        end
        if (m_mode == 0) begin
            if (en) begin m_mode = 1; m_hist.delete(); end
        end else if (m_mode == 1) begin
            if (!en) begin
                m_mode = 0; m_hist.delete();
            end else begin
                if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1;
                m_hist.push_back(pc);
                while (m_hist.size() > SL + 1) void'(m_hist.pop_front());
                cause = 3'd0; hit = '0;
                if (pc == halt_addr) cause = 3'd1;
                for (int i = 0; i < NB; i++)
                    if (cause == 3'd0 && bp_en[i] && pc == bp_tab[i]) begin
                        cause = 3'd2; hit = NB'(1) << i;
                    end
                if (cause == 3'd0 && m_stuck()) cause = 3'd3;
                if (cause == 3'd0 && max_cycles != 0 && m_cnt == max_cycles) cause = 3'd4;
                if (cause != 3'd0) begin
                    m_mode = 2; m_evt = 1'b1; m_hpc = pc; m_cause = cause; m_hit = hit;
                end
            end
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_bp(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [AW-1:0] a2, input logic [AW-1:0] a3);
        bp_tab[0] = a0; bp_tab[1] = a1; bp_tab[2] = a2; bp_tab[3] = a3;
        bp_addr = {a3, a2, a1, a0};
    endtask

    // Drive one cycle; the model's prediction for the coming edge is queued
    task automatic step(input logic e, input logic c, input logic [AW-1:0] p);
        en = e; clr = c; pc = p;
        @(posedge clk);
        model_edge();
        exp_q.push_back(pack_exp());
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin : monitor
        logic [SW-1:0] exp_v;
        logic [SW-1:0] act_v;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {cycle_cnt, halted, halt_evt, halt_cause, halt_pc, bp_hit};
                n_checks++;
                if (act_v === exp_v) n_pass++;
                else $display("FAIL snap @%0t: got cnt=%0h hlt=%0b evt=%0b cause=%0d pc=%0h hit=%0b expected %0h",
                              $time, cycle_cnt, halted, halt_evt, halt_cause, halt_pc, bp_hit, exp_v);
            end
        end
    end

    initial begin : driver
        logic [AW-1:0] p;
        int            stick;
        set_bp(32'h200, 32'h300, 32'h400, 32'h500);
        m_reset();
        #1;
        chk("reset_cnt", 64'(cycle_cnt), 64'd0);
        chk("reset_halted", 64'(halted), 64'd0);
        @(negedge clk);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        rstn = 1'b1;

        // final address: pc steps by 4 from 0
        halt_addr = 32'h1C; bp_en = '0; max_cycles = '0;
        step(1'b1, 1'b0, '0);
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, AW'(k * 4));
        chk("addr_cause", 64'(halt_cause), 64'd1);
        chk("addr_cnt", 64'(cycle_cnt), 64'd8);
        chk("addr_pc", 64'(halt_pc), 64'h1C);
        chk("addr_evt", 64'(halt_evt), 64'd1);
        step(1'b1, 1'b0, 32'h1C);
        chk("addr_evt_drop", 64'(halt_evt), 64'd0);
        chk("addr_hold_cnt", 64'(cycle_cnt), 64'd8);
        step(1'b0, 1'b1, '0);

        // breakpoint: channels 1 and 2 both match, lower wins
        halt_addr = 32'h100; bp_en = 4'b0110;
        set_bp(32'h200, 32'h10, 32'h10, 32'h300);
        step(1'b1, 1'b0, '0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, AW'(k * 4));
        chk("bp_cause", 64'(halt_cause), 64'd2);
        chk("bp_hit", 64'(bp_hit), 64'b0010);
        chk("bp_pc", 64'(halt_pc), 64'h10);
        step(1'b0, 1'b1, '0);
        chk("clr_state", 64'(dbg_state), 64'd0);
        chk("clr_outs", 64'({cycle_cnt, halted, halt_evt, halt_cause, halt_pc, bp_hit}), 64'd0);

        // stuck PC
        bp_en = '0;
        step(1'b1, 1'b0, 32'h8);
        for (int k = 0; k < 17; k++) step(1'b1, 1'b0, 32'h8);
        chk("stuck_cause", 64'(halt_cause), 64'd3);
        chk("stuck_cnt", 64'(cycle_cnt), 64'd17);
        step(1'b0, 1'b1, '0);

        // timeout, then timeout coinciding with the final address
        max_cycles = 5;
        step(1'b1, 1'b0, '0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, AW'(k * 4));
        chk("tmo_cause", 64'(halt_cause), 64'd4);
        chk("tmo_cnt", 64'(cycle_cnt), 64'd5);
        step(1'b0, 1'b1, '0);
        halt_addr = 32'h10;
        step(1'b1, 1'b0, '0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, AW'(k * 4));
        chk("tmo_addr_cause", 64'(halt_cause), 64'd1);
        step(1'b0, 1'b1, '0);

        // pause / resume, then asynchronous reset mid-run
        halt_addr = 32'h1000; max_cycles = '0;
        step(1'b1, 1'b0, '0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, AW'(k * 4));
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'h40);
        chk("pause_cnt", 64'(cycle_cnt), 64'd3);
        chk("pause_state", 64'(dbg_state), 64'd0);
        step(1'b1, 1'b0, 32'h40);
        chk("resume_entry_cnt", 64'(cycle_cnt), 64'd3);
        step(1'b1, 1'b0, 32'h44);
        step(1'b1, 1'b0, 32'h48);
        chk("resume_cnt", 64'(cycle_cnt), 64'd5);
        #2 rstn = 1'b0;
        #1;
        chk("async_cnt", 64'(cycle_cnt), 64'd0);
        chk("async_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        step(1'b1, 1'b0, 32'h4C);
        rstn = 1'b1;

        // randomized runs
        for (int r = 0; r < 40; r++) begin
            halt_addr = AW'($urandom_range(0, 63) * 4);
            set_bp(AW'($urandom_range(0, 15) * 4), AW'($urandom_range(0, 15) * 4),
                   AW'($urandom_range(0, 15) * 4), AW'($urandom_range(0, 15) * 4));
            bp_en = NB'($urandom_range(0, 15));
            max_cycles = ($urandom_range(0, 2) == 0) ? '0 : CW'($urandom_range(3, 40));
            stick = $urandom_range(0, 1);
            step(1'b0, 1'b1, '0);
            p = AW'($urandom_range(0, 31) * 4);
            for (int k = 0; k < 30; k++) begin
                if (stick == 1) begin
                    if ($urandom_range(0, 19) == 0) p = AW'($urandom_range(0, 31) * 4);
                end else if ($urandom_range(0, 1) == 0) begin
                    p = AW'($urandom_range(0, 31) * 4);
                end
                step($urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0, p);
            end
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_watch_monitor.md
PC_WATCH_MONITOR -- requirements
Module: pc_watch_monitor

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 32, meaning PC and address width.
REQ-002 SHALL have parameter NUM_BP, default 4, meaning number of breakpoint channels (1..16).
REQ-003 SHALL have parameter CNT_W, default 32, meaning cycle-counter width.
REQ-004 SHALL have parameter STALL_LIMIT, default 16, meaning consecutive same-PC cycles that count as stuck (>=2).
REQ-005 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port en  in  1  monitor run enable.
REQ-008 SHALL have port clr  in  1  synchronous clear of all status and counters.
REQ-009 SHALL have port pc  in  ADDR_SIZE  PC under observation, sampled each edge.
REQ-010 SHALL have port halt_addr  in  ADDR_SIZE  final-instruction address.
REQ-011 SHALL have port bp_addr  in  NUM_BP*ADDR_SIZE  packed breakpoint addresses; channel i at bits [i*ADDR_SIZE +: ADDR_SIZE].
REQ-012 SHALL have port bp_en  in  NUM_BP  per-channel breakpoint enable.
REQ-013 SHALL have port max_cycles  in  CNT_W  timeout limit; 0 disables timeout.
REQ-014 SHALL have port cycle_cnt  out  CNT_W  RUN cycles counted since last clear.
REQ-015 SHALL have port halted  out  1  high while in HALTED.
REQ-016 SHALL have port halt_evt  out  1  one-cycle pulse on entry to HALTED.
REQ-017 SHALL have port halt_cause  out  3  0 none, 1 halt_addr, 2 breakpoint, 3 stuck, 4 timeout.
REQ-018 SHALL have port halt_pc  out  ADDR_SIZE  PC sampled on the halting edge.
REQ-019 SHALL have port bp_hit  out  NUM_BP  one-hot channel that caused a cause-2 halt, else 0.

Function
REQ-020 SHALL implement FSM states IDLE, RUN, HALTED.
REQ-021 SHALL give clr priority over all other conditions: from any state, next state IDLE; all counters, outputs and pc_prev valid flag zeroed.
REQ-022 SHALL go IDLE->RUN on an edge with en=1; no count or compare on that edge.
REQ-023 SHALL, in RUN with en=0, go to IDLE holding cycle_cnt and all status (pause/resume).
REQ-024 SHALL, in RUN with en=1, increment cycle_cnt each edge, saturating at all ones.
REQ-025 SHALL, in RUN with en=1, evaluate halt conditions on the current pc in this priority: pc==halt_addr; lowest-index i with bp_en[i] and pc==bp_addr[i]; stuck; timeout.
REQ-026 SHALL detect stuck when pc equals pc_prev for STALL_LIMIT consecutive RUN edges; stall counter resets on any pc change, on leaving RUN, and when pc_prev is invalid (first RUN edge after IDLE).
REQ-027 SHALL detect timeout when max_cycles!=0 and the incremented cycle_cnt equals max_cycles.
REQ-028 SHALL, on a halting edge, enter HALTED, still increment cycle_cnt, load halt_pc<=pc, halt_cause, bp_hit, and assert halt_evt for exactly that following cycle.
REQ-029 SHALL in HALTED hold all outputs, ignore en, pc and all watch inputs, and leave only via clr or reset.
REQ-030 SHALL keep halt_cause=0, bp_hit=0, halt_evt=0 outside HALTED entry/hold.
REQ-031 SHALL be fully synthesizable; no simulation-only constructs.

Reset
REQ-032 SHALL, on rstn=0 at any time including mid-RUN, asynchronously force state IDLE and cycle_cnt, halted, halt_evt, halt_cause, halt_pc, bp_hit, stall counter and pc_prev valid flag to 0.
REQ-033 SHALL resume normal operation on the first rising clk edge after rstn returns to 1.

Verification
REQ-034 SHALL cover: en=1, pc steps by 4 from 0, halt_addr=0x1C, bp_en=0 -> halted on edge with pc=0x1C, cause 1, halt_pc=0x1C, cycle_cnt=8, halt_evt high one cycle.
REQ-035 SHALL cover: bp_en=4'b0110, bp_addr[1]=bp_addr[2]=0x10, halt_addr=0x100 -> cause 2, bp_hit=4'b0010, halt_pc=0x10; then clr -> IDLE, all outputs 0.
REQ-036 SHALL cover: pc held at 0x8 from first RUN edge, STALL_LIMIT=16, max_cycles=0 -> cause 3 with cycle_cnt=17.
REQ-037 SHALL cover: max_cycles=5, pc incrementing, no watches matching -> cause 4 with cycle_cnt=5; simultaneous pc==halt_addr on that edge -> cause 1 instead.
REQ-038 SHALL cover: en dropped after 3 RUN edges for 4 cycles then raised -> cycle_cnt holds 3 in IDLE, resumes counting; rstn pulsed low mid-RUN -> all outputs 0 immediately, without a clock edge.
